counter_ctrl_conditioner: RTL and testbench
===========================================

# counter_ctrl_conditioner

Front-end conditioning stage that sits directly upstream of the team's N-bit up/down counter with load and threshold. It turns raw push-button and switch inputs into the counter's clean control set: `enable`, `dec`, `load` and `Load_Ref_value`. Each button is synchronized, debounced and edge-detected, so one press produces exactly one single-cycle step or load command. An optional auto-repeat emits further steps while a button is held.

## Interface
Parameters:
- `N`, 4: width of the load reference value; must match the counter's `N`.
- `DEBOUNCE_CYCLES`, 16: number of consecutive stable synchronized samples required before a button's debounced state changes. Legal range is 2..65535.
- `REPEAT_CYCLES`, 0: auto-repeat period in clock cycles while up or down is held. 0 disables auto-repeat. If nonzero, it must be ≥ 2.

Ports:
- `clock`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-low reset (0 = reset).
- `btn_up`, input, 1: raw, asynchronous, bouncy "count up" button.
- `btn_down`, input, 1: raw "count down" button.
- `btn_load`, input, 1: raw "load" button.
- `sw_ref`, input, N: raw reference switches.
- `enable`, output, 1: single-cycle step pulse to the counter.
- `dec`, output, 1: direction level; 1 = down. Valid whenever `enable` = 1.
- `load`, output, 1: single-cycle load pulse.
- `Load_Ref_value`, output, N: registered reference value, stable whenever `load` = 1.

## Operation
- **Synchronizer:** each raw input (three buttons plus N switch bits) passes through a 2-flop synchronizer.
- **Debounce (per button):** a counter of width $clog2(DEBOUNCE_CYCLES).
  - It counts while the synchronized input differs from the debounced state.
  - It clears to 0 on any agreeing sample.
  - On the DEBOUNCE_CYCLES-th consecutive differing sample, the debounced state flips and the counter clears.
- **Per-button FSM**, states IDLE, FIRE, HOLD:
  - IDLE → FIRE on a debounced rising edge.
  - FIRE lasts one cycle and asserts that button's request.
  - FIRE → HOLD unconditionally.
  - HOLD → IDLE on debounced low.
  - In HOLD, for up/down with REPEAT_CYCLES > 0: a repeat counter runs; every REPEAT_CYCLES cycles spent in HOLD it reasserts the request for one cycle. The load button never repeats.
- **Arbitration** (registered into the outputs):
  - A load request wins. `load` = 1, `Load_Ref_value` ← synchronized `sw_ref`, and any up/down request in the same cycle is dropped, not deferred.
  - Up and down requests in the same cycle cancel: no `enable`, `dec` unchanged.
  - A single up request gives `enable` = 1, `dec` = 0. A single down request gives `enable` = 1, `dec` = 1.
  - `dec` holds its last value between pulses.
- `enable` and `load` are never high in the same cycle. `enable` is never high on two consecutive cycles.

## Timing
- **Reset values (at the first edge with `reset` = 0):**
  - All outputs are 0: `enable`, `dec`, `load`, and `Load_Ref_value` = '0.
  - Synchronizers and debounced states are 0, FSMs are IDLE, and all counters are 0.
- **Press latency:**
  - Edge 0 is the first edge that samples a raw button at 1, and the button stays at 1.
  - The debounced state rises at edge DEBOUNCE_CYCLES+1.
  - The output pulse is high for the one cycle following edge DEBOUNCE_CYCLES+2.
- **Repeat:** further pulses follow at edges DEBOUNCE_CYCLES+2 + k·REPEAT_CYCLES, for k ≥ 1, while the button is held.
- **Bounce rejection:** a glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no pulse and no state change.
- **Release:** no output pulse. A new press is accepted only after the FSM has returned to IDLE.
- **Reset mid-operation:**
  - Reset takes effect at the same edge; any pending pulse is lost.
  - A button held through reset deassertion is treated as a fresh press, with a pulse at DEBOUNCE_CYCLES+2 edges after reset release.
- **Switches:** `sw_ref` is sampled only on the load edge. Switch changes with no load have no output effect.

## Structure
- **Shared package `ctrl_cond_pkg`:**
  - `typedef enum logic [1:0] {IDLE, FIRE, HOLD} btn_state_t;`
  - Constant `SYNC_STAGES` = 2.
- **Sub-module `button_debouncer`**, instantiated 3×, containing:
  - the synchronizer;
  - the debounce counter;
  - the FSM;
  - the repeat counter (enabled per instance by parameter);
  - a one-cycle request output.
- **Top level:** switch synchronizer, arbitration and output registers.

## Test plan
Use DEBOUNCE_CYCLES = 4 and REPEAT_CYCLES = 8 unless stated.
- **Reset:** drive `reset` = 0 for 3 cycles with all buttons high. Expect all outputs = 0, then one `enable` pulse at edge 6 after release, with `dec` = 0.
- **Bounce:** press `btn_up` with glitches 1–3 cycles wide, then hold it stable. Expect exactly one `enable` pulse, 6 edges after the stable start.
- **Down with auto-repeat:** hold `btn_down` for 30 cycles. Expect `enable` pulses at edges 6, 14, 22 and 30, each with `dec` = 1. Expect no pulse on release.
- **Load with simultaneous up:** set `sw_ref` = 4'b1010 and press `btn_load` and `btn_up` on the same edge. Expect `load` = 1 for 1 cycle with `Load_Ref_value` = 4'b1010, and no `enable`.
- **Up/down cancel:** press `btn_up` and `btn_down` on the same edge and hold them for 12 cycles. Expect no `enable` and `dec` unchanged.
- **Repeat disabled:** with REPEAT_CYCLES = 0, hold `btn_up` for 40 cycles. Expect exactly one `enable` pulse.

Source files
------------

// File: rtl/ctrl_cond_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ctrl_cond_pkg: shared types and constants for the counter          |
// | control conditioner.                Rev 1.0                        |
// +--------------------------------------------------------------------+
package ctrl_cond_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } btn_state_t;

  localparam int SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | button_debouncer: synchronize, debounce and edge-detect one button,|
// | with optional auto-repeat while held.  Rev 1.0                     |
// +--------------------------------------------------------------------+
module button_debouncer
  import ctrl_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_req
);

  localparam int              DW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]   DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]          r_db_cnt;
  logic                   r_deb;
  logic                   w_sample;
  logic                   w_flip;
  logic                   w_rise;
  logic                   w_rep_hit;
  btn_state_t             r_state;
  btn_state_t             w_state_nxt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  assign w_sample = r_sync[SYNC_STAGES-1];
  assign w_flip   = (w_sample != r_deb) && (r_db_cnt == DB_LAST);
  // The FSM leaves IDLE on the same edge the debounced state rises.
  assign w_rise   = w_flip && !r_deb;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_db_cnt <= '0;
      r_deb    <= 1'b0;
    end else if (w_sample == r_deb) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_db_cnt <= '0;
      r_deb    <= ~r_deb;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_state_nxt = FIRE;
      FIRE:    w_state_nxt = HOLD;
      HOLD:    if (!r_deb) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  generate
    if (REPEAT_CYCLES > 0) begin : g_repeat
      localparam int            RW      = $clog2(REPEAT_CYCLES);
      localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);
      logic [RW-1:0]            r_rep_cnt;

      always_ff @(posedge clock) begin
        if (!reset || (r_state != HOLD)) begin
          r_rep_cnt <= '0;
        end else if (r_rep_cnt == RP_LAST) begin
          r_rep_cnt <= '0;
        end else begin
          r_rep_cnt <= r_rep_cnt + 1'b1;
        end
      end

      assign w_rep_hit = (r_state == HOLD) && (r_rep_cnt == RP_LAST);
    end else begin : g_no_repeat
      assign w_rep_hit = 1'b0;
    end
  endgenerate

  assign o_req = (r_state == FIRE) || w_rep_hit;

endmodule
`default_nettype wire

// File: rtl/counter_ctrl_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_ctrl_conditioner: turns raw buttons/switches into clean    |
// | enable/dec/load controls for the up/down counter.  Rev 1.0         |
// +--------------------------------------------------------------------+
module counter_ctrl_conditioner
  import ctrl_cond_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_load,
  input  logic [N-1:0] sw_ref,
  output logic         enable,
  output logic         dec,
  output logic         load,
  output logic [N-1:0] Load_Ref_value
);

  logic         w_req_up;
  logic         w_req_dn;
  logic         w_req_ld;
  logic [N-1:0] r_sw_sync [SYNC_STAGES];
  logic         r_enable;
  logic         r_dec;
  logic         r_load;
  logic [N-1:0] r_ref;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_up (
    .clock (clock),
    .reset (reset),
    .i_btn (btn_up),
    .o_req (w_req_up)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_down (
    .clock (clock),
    .reset (reset),
    .i_btn (btn_down),
    .o_req (w_req_dn)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (0)
  ) u_load (
    .clock (clock),
    .reset (reset),
    .i_btn (btn_load),
    .o_req (w_req_ld)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sw_sync[i] <= '0;
    end else begin
      r_sw_sync[0] <= sw_ref;
      for (int i = 1; i < SYNC_STAGES; i++) r_sw_sync[i] <= r_sw_sync[i-1];
    end
  end

  // Load beats steps; simultaneous up+down cancel; a step directly after a
  // step is dropped so enable never stays high two cycles running.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_enable <= 1'b0;
      r_dec    <= 1'b0;
      r_load   <= 1'b0;
      r_ref    <= '0;
    end else begin
      r_load   <= w_req_ld;
      r_enable <= 1'b0;
      if (w_req_ld) begin
        r_ref <= r_sw_sync[SYNC_STAGES-1];
      end else if ((w_req_up ^ w_req_dn) && !r_enable) begin
        r_enable <= 1'b1;
        r_dec    <= w_req_dn;
      end
    end
  end

  assign enable         = r_enable;
  assign dec            = r_dec;
  assign load           = r_load;
  assign Load_Ref_value = r_ref;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_counter_ctrl_conditioner: scoreboard bench, repeat on (inst 0)  |
// | and repeat off (inst 1) driven in parallel.  Rev 1.0               |
// +--------------------------------------------------------------------+
module tb_counter_ctrl_conditioner;

  localparam int N   = 4;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         b_up, b_dn, b_ld;
  logic [N-1:0] sw;
  logic         en0, dec0, ld0, en1, dec1, ld1;
  logic [N-1:0] ref0, ref1;

  always #5 clk = ~clk;

  counter_ctrl_conditioner #(.N(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(8)) u_dut0 (
    .clock(clk), .reset(rst_n), .btn_up(b_up), .btn_down(b_dn), .btn_load(b_ld),
    .sw_ref(sw), .enable(en0), .dec(dec0), .load(ld0), .Load_Ref_value(ref0)
  );

  counter_ctrl_conditioner #(.N(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(0)) u_dut1 (
    .clock(clk), .reset(rst_n), .btn_up(b_up), .btn_down(b_dn), .btn_load(b_ld),
    .sw_ref(sw), .enable(en1), .dec(dec1), .load(ld1), .Load_Ref_value(ref1)
  );

  typedef struct {
    int           edge_no;
    bit           is_load;
    bit           dec;
    logic [N-1:0] refv;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  // Reference model state, advanced once per rising edge.
  bit           s1[3], s2[3], dq[3], dprev[3], raw[3];
  int           run[3];
  int           rise_at[3];
  logic [N-1:0] sws1, sws2;
  int           rep_c[2];
  bit           m_en_prev[2];
  bit           m_dec[2];
  bit           m_rst_edge;

  // A request exists for the output registered at edge cyc if the debounced
  // level rose one edge earlier, or a whole repeat period of holding elapsed.
  function automatic bit btn_req(input int i, input int b);
    int age;
    if (rise_at[b] < 0) return 1'b0;
    if (rise_at[b] == cyc - 1) return 1'b1;
    if (b == 2 || rep_c[i] == 0 || !dprev[b]) return 1'b0;
    age = cyc - 1 - rise_at[b];
    return (age >= rep_c[i]) && (age % rep_c[i] == 0);
  endfunction

  always @(posedge clk) begin
    ev_t ev;
    cyc++;
    raw[0] = b_up; raw[1] = b_dn; raw[2] = b_ld;
    if (!rst_n) begin
      m_rst_edge = 1'b1;
      for (int b = 0; b < 3; b++) begin
        s1[b] = 0; s2[b] = 0; dq[b] = 0; dprev[b] = 0; run[b] = 0; rise_at[b] = -1000;
      end
      sws1 = '0; sws2 = '0;
      for (int i = 0; i < 2; i++) begin m_en_prev[i] = 0; m_dec[i] = 0; end
    end else begin
      m_rst_edge = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (btn_req(i, 2)) begin
          ev = '{cyc, 1'b1, m_dec[i], sws2};
          if (i == 0) q0.push_back(ev); else q1.push_back(ev);
          m_en_prev[i] = 0;
        end else if ((btn_req(i, 0) ^ btn_req(i, 1)) && !m_en_prev[i]) begin
          m_dec[i] = btn_req(i, 1);
          ev = '{cyc, 1'b0, m_dec[i], '0};
          if (i == 0) q0.push_back(ev); else q1.push_back(ev);
          m_en_prev[i] = 1;
        end else begin
          m_en_prev[i] = 0;
        end
      end
      for (int b = 0; b < 3; b++) begin
        dprev[b] = dq[b];
        if (s2[b] != dq[b]) begin
          run[b]++;
          if (run[b] == DEB) begin
            dq[b]  = ~dq[b];
            run[b] = 0;
            if (dq[b]) rise_at[b] = cyc;
          end
        end else begin
          run[b] = 0;
        end
        s2[b] = s1[b];
        s1[b] = raw[b];
      end
      sws2 = sws1;
      sws1 = sw;
    end
  end

  task automatic chk(input int inst, input logic en, input logic d, input logic ld,
                     input logic [N-1:0] rv);
    ev_t e;
    bit  have, due;
    have = (inst == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (inst == 0) ? q0[0] : q1[0];
    due = have && (e.edge_no <= cyc);
    if (en || ld) begin
      total++;
      if (!due) begin
        bad++;
        $display("FAIL pulse_unexpected inst%0d edge=%0d got en=%0b ld=%0b required none",
                 inst, cyc, en, ld);
      end else begin
        if (inst == 0) e = q0.pop_front(); else e = q1.pop_front();
        if (e.edge_no != cyc || e.is_load != ld || e.is_load == en ||
            (ld && rv !== e.refv) || (en && d !== e.dec)) begin
          bad++;
          $display("FAIL pulse_content inst%0d edge=%0d got en=%0b ld=%0b dec=%0b ref=%h required edge=%0d load=%0b dec=%0b ref=%h",
                   inst, cyc, en, ld, d, rv, e.edge_no, e.is_load, e.dec, e.refv);
        end
      end
    end else if (due) begin
      total++;
      bad++;
      if (inst == 0) e = q0.pop_front(); else e = q1.pop_front();
      $display("FAIL pulse_missing inst%0d edge=%0d got none required load=%0b dec=%0b at edge %0d",
               inst, cyc, e.is_load, e.dec, e.edge_no);
    end
    total++;
    if (d !== m_dec[inst]) begin
      bad++;
      $display("FAIL dec_level inst%0d edge=%0d got %0b required %0b", inst, cyc, d, m_dec[inst]);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (m_rst_edge) begin
        total++;
        if ({en0, dec0, ld0, ref0, en1, dec1, ld1, ref1} !== '0) begin
          bad++;
          $display("FAIL reset_outputs edge=%0d got %b required all zero", cyc,
                   {en0, dec0, ld0, ref0, en1, dec1, ld1, ref1});
        end
      end else begin
        chk(0, en0, dec0, ld0, ref0);
        chk(1, en1, dec1, ld1, ref1);
      end
    end
  end

  task automatic drive(input bit u, input bit d, input bit l, input int n);
    b_up = u; b_dn = d; b_ld = l;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int rem[3];
    bit lvl[3];
    rep_c[0] = 8; rep_c[1] = 0;
    rst_n = 1'b0; b_up = 0; b_dn = 0; b_ld = 0; sw = '0;
    @(negedge clk);
    // reset held with up pressed, then released into a fresh press
    drive(1, 0, 0, 3);
    rst_n = 1'b1;
    drive(1, 0, 0, 20);
    drive(0, 0, 0, 20);
    // bounce then stable press
    drive(1, 0, 0, 1); drive(0, 0, 0, 2); drive(1, 0, 0, 2);
    drive(0, 0, 0, 1); drive(1, 0, 0, 3); drive(0, 0, 0, 2);
    drive(1, 0, 0, 20);
    drive(0, 0, 0, 20);
    // down held long enough for several repeats
    drive(0, 1, 0, 30);
    drive(0, 0, 0, 20);
    // load together with up
    sw = 4'b1010;
    drive(1, 0, 1, 6);
    drive(0, 0, 0, 20);
    // up and down cancel
    drive(1, 1, 0, 12);
    drive(0, 0, 0, 20);
    // up held long: repeats on inst 0, single pulse on inst 1
    drive(1, 0, 0, 40);
    drive(0, 0, 0, 20);
    // randomized bouncy buttons, switches and occasional reset
    for (int b = 0; b < 3; b++) begin rem[b] = 0; lvl[b] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = ~lvl[b];
          rem[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
        end
        rem[b]--;
      end
      b_up = lvl[0]; b_dn = lvl[1]; b_ld = lvl[2];
      if ($urandom_range(0, 7) == 0) sw = N'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 40);
    @(posedge clk);
    #1;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL pending_events got q0=%0d q1=%0d required 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
